ycbcr444_to_422: RTL and testbench

- Downstream neighbour of the RGB-to-YCbCr colour-space converter in the OV7670 → Sobel → HDMI pipeline.
- Accepts one 4:4:4 YCbCr pixel per clock together with DE/HSYNC/VSYNC.
- Produces the 16-bit 4:2:2 stream {Y, C} that the HDMI transmitter input expects.
- Chroma is horizontally decimated by 2, with optional pairwise averaging; syncs are delayed to stay aligned with the pixel data.

---
 rtl/ycbcr444_to_422_if.sv | 29 ++
 rtl/ycbcr444_to_422.sv | 122 ++++++++++++
 tb/tb_ycbcr444_to_422.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr444_to_422_if.sv
// ycbcr444_to_422_if
//   Pixel bus bundle for the 4:4:4 -> 4:2:2 chroma decimator.
//   Inputs : de_in, hsync_in, vsync_in, y_in[7:0], cb_in[7:0], cr_in[7:0]
//   Outputs: de_out, hsync_out, vsync_out, data_out[15:0] = {Y, C}, phase_out
//   master : source side (drives the 4:4:4 pixel, receives the 4:2:2 stream)
//   slave  : the converter itself
interface ycbcr444_to_422_if;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  y_in;
    logic [7:0]  cb_in;
    logic [7:0]  cr_in;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [15:0] data_out;
    logic        phase_out;

    modport master (
        output de_in, hsync_in, vsync_in, y_in, cb_in, cr_in,
        input  de_out, hsync_out, vsync_out, data_out, phase_out
    );

    modport slave (
        input  de_in, hsync_in, vsync_in, y_in, cb_in, cr_in,
        output de_out, hsync_out, vsync_out, data_out, phase_out
    );
endinterface

// File: rtl/ycbcr444_to_422.sv
// ycbcr444_to_422
//   Converts a 4:4:4 YCbCr pixel stream into the 16-bit 4:2:2 {Y, C} stream
//   expected by the HDMI transmitter. Chroma is decimated horizontally by 2;
//   DE/HSYNC/VSYNC are delayed by the same fixed 3-clock latency as the data.
//
//   Ports:
//     clk  - pixel clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - ycbcr444_to_422_if.slave (pixel in, 4:2:2 out, syncs, phase_out)
//
//   Parameters:
//     CB_FIRST - 1: even pixel carries Cb, odd carries Cr; 0: swapped
//     BLANK_Y  - Y driven while de_out is low
//     BLANK_C  - C driven while de_out is low
//
//   Build option:
//     YCBCR422_CHROMA_AVG_EN - defined: pairwise chroma averaging with the odd
//                              partner; undefined: co-sited decimation (even
//                              pixel's own chroma is used, odd chroma dropped).
module ycbcr444_to_422 #(
    parameter bit         CB_FIRST = 1'b1,
    parameter logic [7:0] BLANK_Y  = 8'd16,
    parameter logic [7:0] BLANK_C  = 8'd128
) (
    input  logic              clk,
    input  logic              rst,
    ycbcr444_to_422_if.slave  bus
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned SUM_W = PIX_W + 1;

    typedef struct packed {
        logic             de;
        logic             hs;
        logic             vs;
        logic             phase;
        logic [PIX_W-1:0] y;
        logic [PIX_W-1:0] cb;
        logic [PIX_W-1:0] cr;
    } pix_t;

    pix_t             s1_q;
    pix_t             s2_q;
    logic             phase_q;
    logic [PIX_W-1:0] hold_q;

    logic [PIX_W-1:0] cb_sel_c;
    logic [PIX_W-1:0] cr_sel_c;
    logic [PIX_W-1:0] first_c;
    logic [PIX_W-1:0] second_c;

`ifdef YCBCR422_CHROMA_AVG_EN
    // Even pixel in stage 2 averages with its odd partner in stage 1; an
    // orphan (no partner) averages with itself, yielding its own chroma.
    logic             partner_ok_c;
    logic [PIX_W-1:0] partner_cb_c;
    logic [PIX_W-1:0] partner_cr_c;
    logic [SUM_W-1:0] cb_sum_c;
    logic [SUM_W-1:0] cr_sum_c;

    assign partner_ok_c = s1_q.de & s1_q.phase;
    assign partner_cb_c = partner_ok_c ? s1_q.cb : s2_q.cb;
    assign partner_cr_c = partner_ok_c ? s1_q.cr : s2_q.cr;
    assign cb_sum_c     = SUM_W'(s2_q.cb) + SUM_W'(partner_cb_c) + SUM_W'(1);
    assign cr_sum_c     = SUM_W'(s2_q.cr) + SUM_W'(partner_cr_c) + SUM_W'(1);
    assign cb_sel_c     = cb_sum_c[SUM_W-1:1];
    assign cr_sel_c     = cr_sum_c[SUM_W-1:1];
`else
    // Co-sited: the even pixel's own chroma is kept, the odd one is dropped.
    assign cb_sel_c     = s2_q.cb;
    assign cr_sel_c     = s2_q.cr;
`endif

    assign first_c  = CB_FIRST ? cb_sel_c : cr_sel_c;
    assign second_c = CB_FIRST ? cr_sel_c : cb_sel_c;

    // Phase counter plus the three pipeline stages; stage 3 is the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            hold_q        <= '0;
            bus.de_out    <= 1'b0;
            bus.hsync_out <= 1'b0;
            bus.vsync_out <= 1'b0;
            bus.phase_out <= 1'b0;
            bus.data_out  <= {BLANK_Y, BLANK_C};
        end else begin
            // Cleared on blanking so every line starts on an even pixel.
            phase_q <= bus.de_in ? ~phase_q : 1'b0;

            s1_q.de    <= bus.de_in;
            s1_q.hs    <= bus.hsync_in;
            s1_q.vs    <= bus.vsync_in;
            s1_q.phase <= phase_q;
            s1_q.y     <= bus.y_in;
            s1_q.cb    <= bus.cb_in;
            s1_q.cr    <= bus.cr_in;

            s2_q <= s1_q;

            // Second chroma of the pair waits here for the odd pixel.
            if (s2_q.de && !s2_q.phase) begin
                hold_q <= second_c;
            end

            bus.de_out    <= s2_q.de;
            bus.hsync_out <= s2_q.hs;
            bus.vsync_out <= s2_q.vs;
            if (s2_q.de) begin
                bus.phase_out <= s2_q.phase;
                bus.data_out  <= {s2_q.y, (s2_q.phase ? hold_q : first_c)};
            end else begin
                bus.phase_out <= 1'b0;
                bus.data_out  <= {BLANK_Y, BLANK_C};
            end
        end
    end

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// tb_ycbcr444_to_422
//   Self-checking bench for ycbcr444_to_422 (CB_FIRST=1, default blanking).
//   Directed table of the documented pixel/sync cases, a mid-line reset
//   sequence, then randomized lines checked against a line-level model.
//   Expected values follow YCBCR422_CHROMA_AVG_EN the same way as the design.
module tb_ycbcr444_to_422;

    localparam int unsigned N_RAND = 400;
    localparam int unsigned HIST   = 512;
    localparam int unsigned N_VEC  = 19;

`ifdef YCBCR422_CHROMA_AVG_EN
    localparam bit         AVG  = 1'b1;
    localparam logic [7:0] P0_C = 8'h66;
    localparam logic [7:0] P1_C = 8'h7D;
`else
    localparam bit         AVG  = 1'b0;
    localparam logic [7:0] P0_C = 8'h64;
    localparam logic [7:0] P1_C = 8'hC8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ycbcr444_to_422_if bus();

    ycbcr444_to_422 #(
        .CB_FIRST (1'b1),
        .BLANK_Y  (8'd16),
        .BLANK_C  (8'd128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Observed output word: {de, hs, vs, phase, data[15:0]}
    function automatic logic [19:0] o(input logic de, input logic hs, input logic vs,
                                       input logic ph, input logic [15:0] d);
        return {de, hs, vs, ph, d};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] g;
        g = {bus.de_out, bus.hsync_out, bus.vsync_out, bus.phase_out, bus.data_out};
        checks++;
        if (g !== exp) begin
            errors++;
            $display("FAIL %s: got de=%0b hs=%0b vs=%0b ph=%0b data=%04h, expected de=%0b hs=%0b vs=%0b ph=%0b data=%04h",
                     name, g[19], g[18], g[17], g[16], g[15:0],
                     exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        bus.de_in    = de;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.y_in     = y;
        bus.cb_in    = cb;
        bus.cr_in    = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: row k drives its inputs after edge k and expects the
    // outputs seen after edge k (i.e. reflecting the row driven 3 edges earlier).
    typedef struct {
        logic        de, hs, vs;
        logic [7:0]  y, cb, cr;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl [N_VEC];

    function automatic vec_t mk(input logic de, input logic hs, input logic vs,
                                input logic [7:0] y, input logic [7:0] cb,
                                input logic [7:0] cr, input logic [19:0] exp);
        vec_t v;
        v.de = de; v.hs = hs; v.vs = vs; v.y = y; v.cb = cb; v.cr = cr; v.exp = exp;
        return v;
    endfunction

    // Random-phase history for the reference model.
    logic       h_de [HIST];
    logic       h_hs [HIST];
    logic       h_vs [HIST];
    logic [7:0] h_y  [HIST];
    logic [7:0] h_cb [HIST];
    logic [7:0] h_cr [HIST];
    int         h_pos[HIST];

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return 8'(s);
    endfunction

    // Output expected for the input presented at cycle idx: position within the
    // active run decides even/odd; even pairs with the next pixel if it is
    // active, otherwise with itself; odd shows the pair's second (Cr) chroma.
    function automatic logic [19:0] model(input int idx);
        int         p;
        logic [7:0] c;
        if (idx < 0) return o(1'b0, 1'b0, 1'b0, 1'b0, 16'h1080);
        if (!h_de[idx]) return o(1'b0, h_hs[idx], h_vs[idx], 1'b0, 16'h1080);
        if (h_pos[idx] % 2 == 0) begin
            p = h_de[idx+1] ? idx + 1 : idx;
            c = AVG ? avg8(h_cb[idx], h_cb[p]) : h_cb[idx];
        end else begin
            p = idx - 1;
            c = AVG ? avg8(h_cr[p], h_cr[idx]) : h_cr[p];
        end
        return o(1'b1, h_hs[idx], h_vs[idx], 1'(h_pos[idx] % 2), {h_y[idx], c});
    endfunction

    initial begin
        int  run_left;
        logic cur_de;
        logic [19:0] idle;
        idle = o(1'b0, 1'b0, 1'b0, 1'b0, 16'h1080);

        tbl[0]  = mk(1, 0, 0, 8'd50,  8'd100, 8'd200, idle);
        tbl[1]  = mk(1, 0, 0, 8'd60,  8'd103, 8'd50,  idle);
        tbl[2]  = mk(1, 0, 0, 8'd70,  8'd40,  8'd60,  idle);
        tbl[3]  = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   o(1, 0, 0, 0, {8'h32, P0_C}));
        tbl[4]  = mk(0, 1, 0, 8'd0,   8'd0,   8'd0,   o(1, 0, 0, 1, {8'h3C, P1_C}));
        tbl[5]  = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   o(1, 0, 0, 0, 16'h4628));
        tbl[6]  = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   idle);
        tbl[7]  = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   o(0, 1, 0, 0, 16'h1080));
        tbl[8]  = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   idle);
        tbl[9]  = mk(1, 0, 0, 8'd100, 8'd240, 8'd240, idle);
        tbl[10] = mk(1, 0, 0, 8'd101, 8'd240, 8'd240, idle);
        tbl[11] = mk(1, 0, 0, 8'd16,  8'd16,  8'd16,  idle);
        tbl[12] = mk(1, 0, 0, 8'd16,  8'd16,  8'd16,  o(1, 0, 0, 0, 16'h64F0));
        tbl[13] = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   o(1, 0, 0, 1, 16'h65F0));
        tbl[14] = mk(0, 0, 1, 8'd0,   8'd0,   8'd0,   o(1, 0, 0, 0, 16'h1010));
        tbl[15] = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   o(1, 0, 0, 1, 16'h1010));
        tbl[16] = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   idle);
        tbl[17] = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   o(0, 0, 1, 0, 16'h1080));
        tbl[18] = mk(0, 0, 0, 8'd0,   8'd0,   8'd0,   idle);

        // Reset state, checked before any clock edge.
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0);
        #1 rst = 1'b1;
        #2 check("reset_state", idle);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Directed table.
        for (int k = 0; k < int'(N_VEC); k++) begin
            tick();
            check($sformatf("vec%0d", k), tbl[k].exp);
            drive(tbl[k].de, tbl[k].hs, tbl[k].vs, tbl[k].y, tbl[k].cb, tbl[k].cr);
        end

        // Mid-line reset: pixels are in flight and one is on the outputs.
        tick();
        drive(1, 0, 0, 8'd11, 8'd20, 8'd30);
        tick();
        drive(1, 0, 0, 8'd12, 8'd20, 8'd30);
        tick();
        drive(1, 0, 0, 8'd13, 8'd20, 8'd30);
        tick();
        check("pre_reset_pixel", o(1, 0, 0, 0, 16'h0B14));
        #2 rst = 1'b1;
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0);
        #1 check("reset_async", idle);
        tick();
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 8'h55, 8'h77, 8'h99);
        tick();
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        check("post_reset_pixel", o(1, 0, 0, 0, 16'h5577));
        tick();
        check("post_reset_idle", idle);
        for (int i = 0; i < 4; i++) tick();

        // Randomized lines against the reference model.
        run_left = 0;
        cur_de   = 1'b0;
        for (int c = 0; c < int'(N_RAND) + 4; c++) begin
            tick();
            check($sformatf("rand_c%0d", c), model(c - 3));
            if (c >= int'(N_RAND)) begin
                h_de[c] = 1'b0; h_hs[c] = 1'b0; h_vs[c] = 1'b0;
                h_y[c] = 8'd0; h_cb[c] = 8'd0; h_cr[c] = 8'd0;
            end else begin
                if (run_left == 0) begin
                    cur_de   = ~cur_de;
                    run_left = cur_de ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 4));
                end
                run_left--;
                h_de[c] = cur_de;
                h_hs[c] = ($urandom_range(0, 7) == 0);
                h_vs[c] = ($urandom_range(0, 15) == 0);
                h_y[c]  = 8'($urandom);
                h_cb[c] = 8'($urandom);
                h_cr[c] = 8'($urandom);
            end
            h_pos[c] = (h_de[c] && c > 0 && h_de[c-1]) ? h_pos[c-1] + 1 : 0;
            drive(h_de[c], h_hs[c], h_vs[c], h_y[c], h_cb[c], h_cr[c]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
